// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 multiply/divide unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0]    c_idle     = 2'd0;
  localparam logic [1:0]    c_calc     = 2'd1;
  localparam logic [1:0]    c_fix      = 2'd2;
  localparam logic [CW-1:0] c_cnt_init = CW'(WIDTH);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz;

  logic               w_idle_start;
  logic               w_div_op;
  logic               w_b_zero;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_accept;
  logic               w_div0;
  logic               w_mtx;
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_idle_start = start && (r_state == c_idle);
  assign w_div_op     = ~op[2] & op[1];
  assign w_b_zero     = (b == '0);
  // op[0] set selects the unsigned variants
  assign w_a_neg      = ~op[0] & a[WIDTH-1];
  assign w_b_neg      = ~op[0] & b[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -a : a;
  assign w_b_mag      = w_b_neg ? -b : b;
  assign w_accept     = w_idle_start && ~op[2] && !(w_div_op && w_b_zero);
  assign w_div0       = w_idle_start && w_div_op && w_b_zero;
  assign w_mtx        = w_idle_start && (op[2:1] == 2'b10);

  // Multiply: accumulator upper half gains the multiplicand, then shifts right.
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_opb};
  assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_idle;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_opb     <= op[1] ? w_b_mag : w_a_mag;
            r_is_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= c_cnt_init;
            r_dbz     <= 1'b0;
            r_state   <= c_calc;
          end else if (w_div0) begin
            r_hi   <= a;
            r_lo   <= '1;
            r_dbz  <= 1'b1;
            r_done <= 1'b1;
          end else if (w_mtx) begin
            if (op[0]) r_lo <= a;
            else       r_hi <= a;
            r_dbz <= 1'b0;
          end
        end
        c_calc: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= c_fix;
        end
        c_fix: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign busy        = (r_state != c_idle);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (WIDTH=32 and WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam logic [2:0] c_mult  = 3'b000;
  localparam logic [2:0] c_multu = 3'b001;
  localparam logic [2:0] c_div   = 3'b010;
  localparam logic [2:0] c_divu  = 3'b011;
  localparam logic [2:0] c_mthi  = 3'b100;
  localparam logic [2:0] c_mtlo  = 3'b101;
  localparam logic [2:0] c_noop  = 3'b110;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start32 = 1'b0, start8 = 1'b0;
  logic [2:0]  op32 = '0, op8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, dbz32, busy8, done8, dbz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one request, then count busy cycles until done and score the result.
  task automatic run_op(input bit u8, input logic [2:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input exp_t e, input int inj_at);
    int   cyc;
    bit   got;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    if (u8) begin start8 = 1'b1; op8 = op_i; a8 = a_i[7:0]; b8 = b_i[7:0]; end
    else    begin start32 = 1'b1; op32 = op_i; a32 = a_i; b32 = b_i; end
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    cyc = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (u8 ? done8 : done32) begin got = 1'b1; break; end
      if (u8 ? busy8 : busy32) cyc++;
      if (i == inj_at) begin start32 = 1'b1; op32 = c_divu; a32 = 32'd9; b32 = 32'd3; end
      else start32 = 1'b0;
      @(negedge clk);
    end
    start32 = 1'b0;
    x = sb.pop_front();
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no done within 200 cycles, expected done", x.name);
    end else begin
      check({x.name, " hi"}, u8 ? {24'h0, hi8} : hi32, x.hi);
      check({x.name, " lo"}, u8 ? {24'h0, lo8} : lo32, x.lo);
      check({x.name, " dbz"}, {31'h0, (u8 ? dbz8 : dbz32)}, {31'h0, x.dbz});
      check({x.name, " busy_cycles"}, cyc, x.cyc);
    end
  endtask

  task automatic single_cycle(input logic [2:0] op_i, input logic [31:0] a_i);
    @(negedge clk);
    start32 = 1'b1; op32 = op_i; a32 = a_i; b32 = '0;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{c_multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[1]  = '{c_mult,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[2]  = '{c_div,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{c_divu,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[4]  = '{c_div,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[5]  = '{c_div,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33};
    vecs[6]  = '{c_mult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 33};
    vecs[7]  = '{c_multu, 32'h00010000, 32'h00010000, 32'h1,        32'h0,        1'b0, 33};
    vecs[8]  = '{c_div,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0};
    vecs[9]  = '{c_mult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 33};
    vecs[10] = '{c_divu,  32'hFFFFFFFF, 32'd1,        32'h0,        32'hFFFFFFFF, 1'b0, 33};

    repeat (3) @(negedge clk);
    check("reset hi", hi32, 32'h0);
    check("reset lo", lo32, 32'h0);
    check("reset busy", {31'h0, busy32}, 32'h0);
    check("reset done", {31'h0, done32}, 32'h0);
    check("reset dbz", {31'h0, dbz32}, 32'h0);
    check("reset8 hi/lo", {16'h0, hi8, lo8}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      e = '{vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].cyc, $sformatf("vec%0d", i)};
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, e, -1);
    end

    // Divide by zero followed by MTLO, no-op and MTHI
    e = '{32'h64, 32'hFFFFFFFF, 1'b1, 0, "divu_by_zero"};
    run_op(1'b0, c_divu, 32'd100, 32'd0, e, -1);
    single_cycle(c_mtlo, 32'h12345678);
    check("mtlo lo", lo32, 32'h12345678);
    check("mtlo hi kept", hi32, 32'h64);
    check("mtlo dbz", {31'h0, dbz32}, 32'h0);
    check("mtlo done", {31'h0, done32}, 32'h0);
    check("mtlo busy", {31'h0, busy32}, 32'h0);
    single_cycle(c_noop, 32'hDEADBEEF);
    @(negedge clk);
    check("noop busy/done", {30'h0, busy32, done32}, 32'h0);
    check("noop hi", hi32, 32'h64);
    check("noop lo", lo32, 32'h12345678);
    single_cycle(c_mthi, 32'hCAFEF00D);
    check("mthi hi", hi32, 32'hCAFEF00D);
    check("mthi lo kept", lo32, 32'h12345678);

    // Start while busy is ignored
    e = '{32'h0, 32'd42, 1'b0, 33, "multu_ignore_start"};
    run_op(1'b0, c_multu, 32'd6, 32'd7, e, 3);
    repeat (2) @(negedge clk);
    check("no queued op busy", {31'h0, busy32}, 32'h0);
    check("no queued op lo", lo32, 32'd42);

    // Asynchronous reset mid-operation
    @(negedge clk);
    start32 = 1'b1; op32 = c_multu; a32 = 32'd6; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (8) @(negedge clk);
    check("pre-reset busy", {31'h0, busy32}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async rst busy", {31'h0, busy32}, 32'h0);
    check("async rst lo", lo32, 32'h0);
    check("async rst hi", hi32, 32'h0);
    check("async rst done/dbz", {30'h0, done32, dbz32}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    e = '{32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, "mult_after_reset"};
    run_op(1'b0, c_mult, 32'hFFFFFFFD, 32'd5, e, -1);

    // WIDTH=8 instance
    e = '{32'h00, 32'h80, 1'b0, 9, "w8_div_overflow"};
    run_op(1'b1, c_div, 32'h80, 32'hFF, e, -1);
    e = '{32'h04, 32'h1C, 1'b0, 9, "w8_divu"};
    run_op(1'b1, c_divu, 32'hC8, 32'h07, e, -1);
    e = '{32'hFF, 32'hEB, 1'b0, 9, "w8_mult"};
    run_op(1'b1, c_mult, 32'hF9, 32'h03, e, -1);

    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard leftover: got %0d entries, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
